// File: rtl/mem_pkg.sv
// Shared definitions for the two-requester memory arbiter: default memory
// geometry and the FSM state encoding.
package mem_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 11;
   localparam int DEFAULT_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone valid requester always wins, and on a tie
// the requester that did not win the previous accept is chosen.
module rr_arbiter2 (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // last_grant names the requester that won the previous accept
   assign grant[0] = valid0 & (~valid1 | last_grant);
   assign grant[1] = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between two requesters with a
// three-state IDLE/ACCESS/CAPTURE sequence and round-robin arbitration.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  mem_write_en,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   state_t                state;
   state_t                next_state;
   logic [1:0]            grant;
   logic                  last_grant;
   logic                  accept;
   logic                  lat_we;
   logic                  lat_owner;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;

   rr_arbiter2 u_rr (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (|grant) begin
               accept     = 1'b1;
               next_state = ACCESS;
            end
         end
         ACCESS:  next_state = CAPTURE;
         CAPTURE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign req0_ready = accept & grant[0] & ~rst;
   assign req1_ready = accept & grant[1] & ~rst;

   // The latched request registers drive the memory port directly, so the
   // address and data hold their last values whenever the FSM is idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         lat_we     <= 1'b0;
         lat_owner  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_rdata <= '0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         if (accept) begin
            last_grant <= grant[1];
            lat_owner  <= grant[1];
            lat_we     <= grant[1] ? req1_we    : req0_we;
            lat_addr   <= grant[1] ? req1_addr  : req0_addr;
            lat_wdata  <= grant[1] ? req1_wdata : req0_wdata;
         end
         if (state == CAPTURE) begin
            if (lat_owner) begin
               rsp1_valid <= 1'b1;
               rsp1_rdata <= lat_we ? '0 : mem_read_data;
            end else begin
               rsp0_valid <= 1'b1;
               rsp0_rdata <= lat_we ? '0 : mem_read_data;
            end
         end
      end
   end

   // Reset must block a write even mid-ACCESS, before the FSM has left it.
   assign mem_write_en = (state == ACCESS) & lat_we & ~rst;
   assign mem_address  = lat_addr;
   assign mem_data_in  = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read memory model behind it.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req0_we = 1'b0;
   logic [10:0] req0_addr = '0;
   logic [15:0] req0_wdata = '0;
   logic        req1_valid = 1'b0, req1_we = 1'b0;
   logic [10:0] req1_addr = '0;
   logic [15:0] req1_wdata = '0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [15:0] rsp0_rdata, rsp1_rdata;
   logic        mem_write_en;
   logic [10:0] mem_address;
   logic [15:0] mem_data_in;
   logic [15:0] mem_read_data;
   logic [15:0] mem [0:2047];

   int tests_run = 0;
   int tests_failed = 0;

   mem_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .mem_write_en(mem_write_en), .mem_address(mem_address),
      .mem_data_in(mem_data_in), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write_en) mem[mem_address] <= mem_data_in;
      mem_read_data <= mem[mem_address];
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic setReq(input int p, input logic v, input logic we, input logic [10:0] a, input logic [15:0] d);
      if (p == 0) begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
      end
   endtask

   // One transaction from requester p; inputs are scrambled right after accept.
   task automatic applyStimulus(input int p, input logic we, input logic [10:0] a,
                                input logic [15:0] d, input logic [15:0] exp_rdata, input string tag);
      int waited = 0;
      @(negedge clk);
      setReq(p, 1'b1, we, a, d);
      #1;
      while (((p == 0) ? req0_ready : req1_ready) !== 1'b1 && waited < 10) begin
         @(negedge clk); #1;
         waited++;
      end
      if (waited == 10) begin
         checkOutput({tag, " accept timeout"}, 32'(0), 32'(1));
         setReq(p, 1'b0, 1'b0, '0, '0);
         return;
      end
      checkOutput({tag, " other ready"}, 32'((p == 0) ? req1_ready : req0_ready), 32'(0));
      @(posedge clk);
      @(negedge clk);
      setReq(p, 1'b0, ~we, ~a, ~d);
      #1;
      checkOutput({tag, " access we"}, 32'(mem_write_en), 32'(we));
      checkOutput({tag, " access addr"}, 32'(mem_address), 32'(a));
      if (we) checkOutput({tag, " access data"}, 32'(mem_data_in), 32'(d));
      checkOutput({tag, " early rsp"}, 32'({rsp1_valid, rsp0_valid}), 32'(0));
      @(negedge clk);
      checkOutput({tag, " capture we"}, 32'(mem_write_en), 32'(0));
      checkOutput({tag, " capture addr"}, 32'(mem_address), 32'(a));
      @(negedge clk);
      checkOutput({tag, " rsp valid"}, 32'({rsp1_valid, rsp0_valid}), (p == 0) ? 32'(1) : 32'(2));
      checkOutput({tag, " rsp rdata"}, 32'((p == 0) ? rsp0_rdata : rsp1_rdata), 32'(exp_rdata));
      @(negedge clk);
      checkOutput({tag, " rsp pulse end"}, 32'({rsp1_valid, rsp0_valid}), 32'(0));
   endtask

   logic [10:0] c_addr [4];
   logic [15:0] c_data [4];
   int          c_port [4];

   initial begin
      c_addr = '{11'h005, 11'h7FF, 11'h000, 11'h010};
      c_data = '{16'hBEEF, 16'h1234, 16'hC0DE, 16'h5555};
      c_port = '{0, 1, 0, 1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset rsp valid", 32'({rsp1_valid, rsp0_valid}), 32'(0));
      checkOutput("reset rsp0 rdata", 32'(rsp0_rdata), 32'(0));
      checkOutput("reset rsp1 rdata", 32'(rsp1_rdata), 32'(0));
      checkOutput("reset mem we", 32'(mem_write_en), 32'(0));
      checkOutput("reset mem addr", 32'(mem_address), 32'(0));
      checkOutput("reset mem data", 32'(mem_data_in), 32'(0));
      checkOutput("reset ready", 32'({req1_ready, req0_ready}), 32'(0));

      applyStimulus(0, 1'b1, 11'h000, 16'hC0DE, 16'h0000, "pre w000");
      applyStimulus(1, 1'b1, 11'h010, 16'h5555, 16'h0000, "pre w010");
      applyStimulus(0, 1'b1, 11'h005, 16'hBEEF, 16'h0000, "w005");
      applyStimulus(0, 1'b0, 11'h005, 16'h0000, 16'hBEEF, "r005");
      applyStimulus(1, 1'b1, 11'h7FF, 16'h1234, 16'h0000, "w7ff");
      applyStimulus(1, 1'b0, 11'h7FF, 16'h0000, 16'h1234, "r7ff");
      applyStimulus(1, 1'b0, 11'h000, 16'h0000, 16'hC0DE, "r000");

      // Reset lands in the ACCESS cycle of a write that must never commit
      @(negedge clk);
      setReq(0, 1'b1, 1'b1, 11'h010, 16'hAAAA);
      #1;
      checkOutput("rstw ready", 32'(req0_ready), 32'(1));
      @(posedge clk);
      @(negedge clk);
      setReq(0, 1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      #1;
      checkOutput("rstw gated we", 32'(mem_write_en), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rstw mem addr", 32'(mem_address), 32'(0));
      for (int i = 0; i < 3; i++) begin
         checkOutput("rstw no rsp", 32'({rsp1_valid, rsp0_valid}), 32'(0));
         @(negedge clk);
      end
      applyStimulus(1, 1'b0, 11'h010, 16'h0000, 16'h5555, "r010 after rst");

      // Both requesters contend; every IDLE cycle overlaps the previous response
      @(negedge clk);
      setReq(0, 1'b1, 1'b0, c_addr[0], 16'h0000);
      setReq(1, 1'b1, 1'b0, c_addr[1], 16'h0000);
      #1;
      for (int k = 0; k < 4; k++) begin
         checkOutput("rr ready0", 32'(req0_ready), 32'(c_port[k] == 0));
         checkOutput("rr ready1", 32'(req1_ready), 32'(c_port[k] == 1));
         if (k == 0) begin
            checkOutput("rr first rsp", 32'({rsp1_valid, rsp0_valid}), 32'(0));
         end else begin
            checkOutput("rr rsp owner", 32'({rsp1_valid, rsp0_valid}), (c_port[k-1] == 0) ? 32'(1) : 32'(2));
            checkOutput("rr rsp data", 32'((c_port[k-1] == 0) ? rsp0_rdata : rsp1_rdata), 32'(c_data[k-1]));
         end
         @(posedge clk);
         @(negedge clk);
         if (k < 2) begin
            setReq(c_port[k], 1'b1, 1'b0, c_addr[k+2], 16'h0000);
         end else if (k == 3) begin
            setReq(0, 1'b0, 1'b0, '0, '0);
            setReq(1, 1'b0, 1'b0, '0, '0);
         end
         #1;
         checkOutput("rr access addr", 32'(mem_address), 32'(c_addr[k]));
         @(negedge clk);
         checkOutput("rr capture we", 32'(mem_write_en), 32'(0));
         checkOutput("rr capture rsp", 32'({rsp1_valid, rsp0_valid}), 32'(0));
         @(negedge clk);
         #1;
      end
      checkOutput("rr last rsp owner", 32'({rsp1_valid, rsp0_valid}), 32'(2));
      checkOutput("rr last rsp data", 32'(rsp1_rdata), 32'(16'h5555));
      @(negedge clk);
      checkOutput("rr no extra rsp", 32'({rsp1_valid, rsp0_valid}), 32'(0));
      checkOutput("rr idle ready", 32'({req1_ready, req0_ready}), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, word-address width of the shared memory (2048 words).
REQ-002 Parameter DATA_WIDTH, default 16, memory word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents a transaction.
REQ-006 reqN_ready  output  1  arbiter accepts requester N's transaction this cycle.
REQ-007 reqN_we  input  1  1 = write, 0 = read.
REQ-008 reqN_addr  input  ADDR_WIDTH  word address.
REQ-009 reqN_wdata  input  DATA_WIDTH  write data.
REQ-010 rspN_valid  output  1  one-cycle pulse: requester N's transaction is complete.
REQ-011 rspN_rdata  output  DATA_WIDTH  read data; valid only while rspN_valid is high.
REQ-012 mem_write_en  output  1  drives the memory write_en.
REQ-013 mem_address  output  ADDR_WIDTH  drives the memory address.
REQ-014 mem_data_in  output  DATA_WIDTH  drives the memory data_in.
REQ-015 mem_read_data  input  DATA_WIDTH  from the memory read_data.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS, CAPTURE.
REQ-017 reqN_ready SHALL be high only in IDLE, only for the granted requester, and only when that requester's reqN_valid is high.
REQ-018 A transaction SHALL be accepted on the edge where reqN_valid and reqN_ready are both high.
REQ-019 On acceptance, the FSM SHALL go IDLE->ACCESS and latch we, addr, wdata and the requester ID.
REQ-020 In ACCESS, mem_address and mem_data_in SHALL carry the latched values, and mem_write_en SHALL equal the latched we.
REQ-021 ACCESS SHALL always be followed by CAPTURE.
REQ-022 In CAPTURE, mem_address SHALL be held and mem_write_en SHALL be 0.
REQ-023 On the CAPTURE->IDLE edge, rspN_rdata SHALL register mem_read_data for a read and 0 for a write.
REQ-024 On that same edge, rspN_valid of the owning requester SHALL be set high for exactly one cycle.
REQ-025 Latency: accept at edge E, write commits at edge E+1, rspN_valid is high in the cycle after edge E+2.
REQ-026 Maximum throughput SHALL be one transaction per 3 cycles; a new accept may occur in the same cycle rspN_valid is high.
REQ-027 Arbitration SHALL be two-way round-robin: with only one valid requester, grant it.
REQ-028 With both requesters valid, the arbiter SHALL grant the requester not granted at the last accept.
REQ-029 The round-robin pointer SHALL update only on an accept.
REQ-030 In IDLE, mem_write_en SHALL be 0; mem_address and mem_data_in SHALL hold their last values.
REQ-031 mem_write_en SHALL be gated low combinationally while rst is high, so no write commits during reset.
REQ-032 Changes to reqN inputs after acceptance SHALL NOT affect the in-flight transaction.
REQ-033 Address 2^ADDR_WIDTH-1 SHALL be passed through unmodified; the arbiter performs no address arithmetic or wrap.

Reset
REQ-034 While rst is high at an edge, the FSM SHALL go to IDLE, and rsp0_valid, rsp1_valid and mem_write_en SHALL be cleared to 0.
REQ-035 Reset SHALL also clear rsp0_rdata, rsp1_rdata, mem_address and mem_data_in to 0, and set the pointer so req0 wins the first tie.
REQ-036 Reset during ACCESS or CAPTURE SHALL abandon the transaction with no rspN_valid; requesters re-issue.

Structure
REQ-037 ADDR_WIDTH/DATA_WIDTH defaults and the IDLE/ACCESS/CAPTURE encodings SHALL live in shared package mem_pkg.
REQ-038 Round-robin grant logic SHALL be the sub-module rr_arbiter2 (inputs: two valids and the pointer; output: one-hot grant).

Verification
REQ-039 Reset, then req0 write addr 0x005 data 0xBEEF, then req0 read 0x005 -> rsp0_valid pulses 3 cycles after each accept; the read returns 0xBEEF.
REQ-040 Both requesters valid continuously for 4 transactions -> grants in order 0,1,0,1; each rsp goes only to its owner.
REQ-041 req1 write 0x7FF data 0x1234, then read 0x7FF -> 0x1234; memory word 0x000 is unchanged.
REQ-042 rst asserted in the ACCESS cycle of a write of 0xAAAA to 0x010 -> mem_write_en is 0 that cycle, no rsp pulse, and a later read of 0x010 returns its prior value.
REQ-043 reqN inputs changed in the cycle after accept -> the memory sees the originally latched addr/data.
REQ-044 Back-to-back traffic: a new accept occurs in the cycle rspN_valid is high -> sustains one transaction per 3 cycles with no dropped or duplicated responses.
